button_event_arbiter: RTL and testbench

Collects N raw push-button inputs, debounces each one, and turns every completed press-and-release into a single event. Events are queued as per-button pending bits and shared out to one consumer through a round-robin arbiter with a valid/ready handshake. The block sits between the board's push buttons and the control FSMs that react to button commands, so no other block needs its own debouncer.

---
 rtl/button_pkg.sv | 11 +
 rtl/btn_debounce_cell.sv | 48 ++++
 rtl/button_event_arbiter.sv | 87 ++++++++
 tb/tb_button_event_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants for the push-button front end: default debounce time,
// button level encoding and the supported channel count.
package button_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 500_000;
    localparam int unsigned MAX_NUM_BTN            = 16;

    localparam logic PUSHED   = 1'b1;
    localparam logic RELEASED = 1'b0;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button channel: 2-FF synchronizer, stability counter and debounced level,
// with a single-cycle pulse on the edge where a release is accepted.
module btn_debounce_cell
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic release_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             expired;

    assign differs       = (sync_b != level);
    assign expired       = differs && (cnt == CNT_W'(DEBOUNCE_LIMIT - 1));
    // Combinational so the pending bit is set on the same edge the level falls.
    assign release_pulse = expired && (level == PUSHED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= RELEASED;
            sync_b <= RELEASED;
            level  <= RELEASED;
            cnt    <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            if (!differs) begin
                cnt <= '0;
            end else if (expired) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces NUM_BTN buttons, latches one pending event per completed release
// and hands them to a single consumer through a round-robin valid/ready slot.
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int unsigned  NUM_BTN        = 4,
    parameter int unsigned  DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    localparam int unsigned IDX_W          = $clog2(NUM_BTN)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_BTN-1:0] i_btn,
    input  logic               i_evt_ready,
    input  logic               i_clr_overflow,
    output logic               o_evt_valid,
    output logic [IDX_W-1:0]   o_evt_id,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic               o_evt_overflow
);

    logic [NUM_BTN-1:0] release_vec;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] grant_vec;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic               slot_free;
    logic               ovf_set;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_cell (
            .clk          (i_clk),
            .rst_n        (i_rst_n),
            .btn_raw      (i_btn[g]),
            .level        (o_btn_level[g]),
            .release_pulse(release_vec[g])
        );
    end

    // Search starts one past the last grant and wraps, ending on last_grant itself.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_BTN; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % NUM_BTN);
            if (!found && pending[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign slot_free = !o_evt_valid || i_evt_ready;
    assign grant_vec = (slot_free && found) ? (NUM_BTN'(1) << pick) : '0;
    assign ovf_set   = |(release_vec & pending & ~grant_vec);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending        <= '0;
            last_grant     <= IDX_W'(NUM_BTN - 1);
            o_evt_valid    <= 1'b0;
            o_evt_id       <= '0;
            o_evt_overflow <= 1'b0;
        end else begin
            pending <= (pending & ~grant_vec) | release_vec;
            if (slot_free) begin
                if (found) begin
                    o_evt_valid <= 1'b1;
                    o_evt_id    <= pick;
                    last_grant  <= pick;
                end else begin
                    o_evt_valid <= 1'b0;
                end
            end
            if (ovf_set) begin
                o_evt_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                o_evt_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (NUM_BTN=4, DEBOUNCE_LIMIT=4) with an
// expected-event queue drained by a separate handshake monitor.
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       ready;
    logic       clr;
    logic       valid;
    logic [1:0] id;
    logic [3:0] level;
    logic       ovf;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] sb[$];
    logic [1:0] exp_id;

    button_event_arbiter #(
        .NUM_BTN       (4),
        .DEBOUNCE_LIMIT(4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_btn         (btn),
        .i_evt_ready   (ready),
        .i_clr_overflow(clr),
        .o_evt_valid   (valid),
        .o_evt_id      (id),
        .o_btn_level   (level),
        .o_evt_overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 32'(valid), 0);
        check({name, "_id"}, 32'(id), 0);
        check({name, "_level"}, 32'(level), 0);
        check({name, "_ovf"}, 32'(ovf), 0);
    endtask

    // Monitor: every accepted event must match the oldest expected id.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got id %0d expected none at %0t", id, $time);
            end else begin
                exp_id = sb.pop_front();
                if (id !== exp_id) begin
                    errors++;
                    $display("FAIL evt_id: got %0d expected %0d at %0t", id, exp_id, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        btn   = 4'b1011;
        ready = 1'b1;
        clr   = 1'b0;
        tick(3);
        check_idle("rst_hold");
        btn = 4'b0000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(10);
        check_idle("rst_release");

        // 3-cycle glitch must never reach the debounced level
        btn = 4'b0001;
        tick(3);
        btn = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_level", 32'(level), 0);
        end
        check("glitch_valid", 32'(valid), 0);

        // clean press/release on channel 0
        btn = 4'b0001;
        tick(5);
        check("press_level_e5", 32'(level), 0);
        tick(1);
        check("press_level_e6", 32'(level), 1);
        check("press_no_evt", 32'(valid), 0);
        tick(4);
        btn = 4'b0000;
        sb.push_back(2'd0);
        tick(5);
        check("rel_level_e5", 32'(level), 1);
        tick(1);
        check("rel_level_e6", 32'(level), 0);
        check("rel_valid_e6", 32'(valid), 0);
        tick(1);
        check("rel_valid_e7", 32'(valid), 1);
        check("rel_id_e7", 32'(id), 0);
        tick(1);
        check("rel_valid_after", 32'(valid), 0);
        tick(5);

        // simultaneous releases on 1,2,3
        btn = 4'b1110;
        tick(10);
        btn = 4'b0000;
        sb.push_back(2'd1);
        sb.push_back(2'd2);
        sb.push_back(2'd3);
        tick(7);
        check("rr_a_id1", 32'(id), 1);
        tick(1);
        check("rr_a_id2", 32'(id), 2);
        tick(1);
        check("rr_a_id3", 32'(id), 3);
        check("rr_a_valid3", 32'(valid), 1);
        tick(1);
        check("rr_a_done", 32'(valid), 0);
        tick(5);

        // last grant was 3, so channel 0 wins before 3
        btn = 4'b1001;
        tick(10);
        btn = 4'b0000;
        sb.push_back(2'd0);
        sb.push_back(2'd3);
        tick(7);
        check("rr_b_id0", 32'(id), 0);
        tick(1);
        check("rr_b_id3", 32'(id), 3);
        tick(1);
        check("rr_b_done", 32'(valid), 0);
        tick(5);

        // backpressure: slot + pending hold two id 2 events, third overflows
        ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            btn = 4'b0100;
            tick(10);
            btn = 4'b0000;
            tick(10);
            check("bp_valid", 32'(valid), 1);
            check("bp_id", 32'(id), 2);
            check("bp_ovf", 32'(ovf), (r == 2) ? 1 : 0);
        end
        sb.push_back(2'd2);
        sb.push_back(2'd2);
        ready = 1'b1;
        tick(1);
        check("bp_second_valid", 32'(valid), 1);
        check("bp_second_id", 32'(id), 2);
        tick(1);
        check("bp_drained", 32'(valid), 0);
        check("bp_ovf_sticky", 32'(ovf), 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("bp_ovf_cleared", 32'(ovf), 0);
        tick(3);

        // asynchronous reset with an event held and a counter mid-count
        ready = 1'b0;
        btn = 4'b0010;
        tick(10);
        btn = 4'b0000;
        tick(10);
        check("mid_valid", 32'(valid), 1);
        check("mid_id", 32'(id), 1);
        btn = 4'b0010;
        tick(4);
        #1 rst_n = 1'b0;
        #1;
        check_idle("mid_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(5);
        check("post_press_e5", 32'(level), 0);
        tick(1);
        check("post_press_e6", 32'(level), 4'b0010);
        tick(4);
        ready = 1'b1;
        btn = 4'b0000;
        sb.push_back(2'd1);
        tick(6);
        check("post_rel_e6_level", 32'(level), 0);
        check("post_rel_e6_valid", 32'(valid), 0);
        tick(1);
        check("post_rel_e7_valid", 32'(valid), 1);
        check("post_rel_e7_id", 32'(id), 1);
        tick(5);

        check("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
